// File: rtl/cv32e40p_trace_buffer.sv
// Multi-channel retire-trace capture: round-robin arbitrated, time-stamped records into one FWFT FIFO.
// A record accepted in cycle N is visible in cycle N+1. When the FIFO is full the cores are either stalled or the records are dropped and counted.
module cv32e40p_trace_buffer #(
    parameter int NUM_CHANNELS  = 2,
    parameter int DEPTH         = 16,
    parameter int PC_WIDTH      = 32,
    parameter int DATA_WIDTH    = 32,
    parameter bit STALL_ON_FULL = 1'b0,
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             enable_i,
    input  logic                             clear_i,
    input  logic [NUM_CHANNELS-1:0]          ch_valid_i,
    output logic [NUM_CHANNELS-1:0]          ch_ready_o,
    input  logic [NUM_CHANNELS*PC_WIDTH-1:0] ch_pc_i,
    input  logic [NUM_CHANNELS*32-1:0]       ch_instr_i,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_wdata_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [CW-1:0]                    out_channel_o,
    output logic [PC_WIDTH-1:0]              out_pc_o,
    output logic [31:0]                      out_instr_o,
    output logic [DATA_WIDTH-1:0]            out_wdata_o,
    output logic [31:0]                      out_timestamp_o,
    output logic [LW-1:0]                    level_o,
    output logic [15:0]                      drop_count_o,
    output logic                             overflow_o
);

    typedef struct packed {
        logic [CW-1:0]         channel;
        logic [PC_WIDTH-1:0]   pc;
        logic [31:0]           instr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [31:0]           ts;
    } rec_t;

    rec_t            mem [DEPTH];
    rec_t            wr_rec;
    rec_t            head;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;
    logic [LW-1:0]   level;
    logic [31:0]     ts;
    logic [CW-1:0]   rr_ptr;
    logic [15:0]     drop_cnt;
    logic            overflow;

    logic [CW-1:0]   cand;
    logic            cand_vld;
    int              idx;
    logic [3:0]      nvalid;
    logic [3:0]      drop_now;
    logic [16:0]     drop_sum;
    logic            pop;
    logic            space;
    logic            push;

    // Scan downwards so the channel closest to the pointer is the last one assigned.
    always_comb begin
        cand     = '0;
        cand_vld = 1'b0;
        idx      = 0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NUM_CHANNELS;
            if (ch_valid_i[idx]) begin
                cand     = CW'(idx);
                cand_vld = 1'b1;
            end
        end
    end

    always_comb begin
        nvalid = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            nvalid = nvalid + 4'(ch_valid_i[c]);
        end
    end

    assign pop   = out_valid_o && out_ready_i;
    assign space = (level < LW'(DEPTH)) || pop;
    assign push  = enable_i && cand_vld && space;

    assign drop_now = (!STALL_ON_FULL && enable_i) ? (nvalid - {3'b000, push}) : 4'd0;
    assign drop_sum = {1'b0, drop_cnt} + 17'(drop_now);

    always_comb begin
        ch_ready_o = '1;
        if (STALL_ON_FULL && enable_i) begin
            ch_ready_o = '0;
            if (cand_vld && space) ch_ready_o[cand] = 1'b1;
        end
    end

    always_comb begin
        wr_rec.channel = cand;
        wr_rec.pc      = ch_pc_i[int'(cand)*PC_WIDTH +: PC_WIDTH];
        wr_rec.instr   = ch_instr_i[int'(cand)*32 +: 32];
        wr_rec.wdata   = ch_wdata_i[int'(cand)*DATA_WIDTH +: DATA_WIDTH];
        wr_rec.ts      = ts;
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) mem[wr_idx] <= wr_rec;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            level    <= '0;
            ts       <= '0;
            rr_ptr   <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clear_i) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            level    <= '0;
            ts       <= '0;
            rr_ptr   <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_idx <= wr_idx + 1'b1;
                rr_ptr <= (cand == CW'(NUM_CHANNELS - 1)) ? '0 : cand + 1'b1;
            end
            if (pop) rd_idx <= rd_idx + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (enable_i) ts <= ts + 32'd1;
            if (drop_now != 4'd0) begin
                drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                overflow <= 1'b1;
            end
        end
    end

    assign head            = mem[rd_idx];
    assign out_valid_o     = (level != '0);
    assign out_channel_o   = head.channel;
    assign out_pc_o        = head.pc;
    assign out_instr_o     = head.instr;
    assign out_wdata_o     = head.wdata;
    assign out_timestamp_o = head.ts;
    assign level_o         = level;
    assign drop_count_o    = drop_cnt;
    assign overflow_o      = overflow;

endmodule

// File: tb/tb_cv32e40p_trace_buffer.sv
// Bench: a stalling and a dropping instance share stimulus; a queue-level model checks both every cycle.
module tb_cv32e40p_trace_buffer;

    localparam int N = 3;
    localparam int D = 4;

    logic clk, rst, enable, clear, out_ready;
    logic [N-1:0]    ch_valid;
    logic [N*32-1:0] ch_pc, ch_instr, ch_wdata;

    logic [1:0]           ovld;
    logic [1:0][N-1:0]    rdy;
    logic [1:0][1:0]      och;
    logic [1:0][31:0]     opc, oins, owd, ots;
    logic [1:0][2:0]      lvl;
    logic [1:0][15:0]     dcnt;
    logic [1:0]           ovf;

    cv32e40p_trace_buffer #(.NUM_CHANNELS(N), .DEPTH(D), .PC_WIDTH(32), .DATA_WIDTH(32), .STALL_ON_FULL(1'b1)) dut_s (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
        .ch_valid_i(ch_valid), .ch_ready_o(rdy[0]), .ch_pc_i(ch_pc), .ch_instr_i(ch_instr), .ch_wdata_i(ch_wdata),
        .out_valid_o(ovld[0]), .out_ready_i(out_ready), .out_channel_o(och[0]), .out_pc_o(opc[0]),
        .out_instr_o(oins[0]), .out_wdata_o(owd[0]), .out_timestamp_o(ots[0]), .level_o(lvl[0]),
        .drop_count_o(dcnt[0]), .overflow_o(ovf[0]));

    cv32e40p_trace_buffer #(.NUM_CHANNELS(N), .DEPTH(D), .PC_WIDTH(32), .DATA_WIDTH(32), .STALL_ON_FULL(1'b0)) dut_d (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
        .ch_valid_i(ch_valid), .ch_ready_o(rdy[1]), .ch_pc_i(ch_pc), .ch_instr_i(ch_instr), .ch_wdata_i(ch_wdata),
        .out_valid_o(ovld[1]), .out_ready_i(out_ready), .out_channel_o(och[1]), .out_pc_o(opc[1]),
        .out_instr_o(oins[1]), .out_wdata_o(owd[1]), .out_timestamp_o(ots[1]), .level_o(lvl[1]),
        .drop_count_o(dcnt[1]), .overflow_o(ovf[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [31:0] pc, instr, wdata, ts;
    } mrec_t;

    // Model state, index 0 = stalling instance, 1 = dropping instance.
    mrec_t       m_mem [2][D];
    int          m_head [2];
    int          m_cnt [2];
    int          m_ptr [2];
    int          m_dc [2];
    bit          m_ov [2];
    logic [31:0] m_ts [2];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[inst %0d] t=%0t got %h want %h", name, k, $time, act, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_head[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
            m_dc[k] = 0; m_ov[k] = 1'b0; m_ts[k] = 32'd0;
        end
    endtask

    function automatic int cand_of(int k);
        for (int i = 0; i < N; i++)
            if (ch_valid[(m_ptr[k] + i) % N]) return (m_ptr[k] + i) % N;
        return -1;
    endfunction

    function automatic bit has_space(int k);
        return (m_cnt[k] < D) || (m_cnt[k] > 0 && out_ready);
    endfunction

    task automatic model_update(int k);
        int  c, nv, drops;
        bit  pop, push;
        mrec_t r;
        c = cand_of(k);
        if (clear) begin
            m_head[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
            m_dc[k] = 0; m_ov[k] = 1'b0; m_ts[k] = 32'd0;
            return;
        end
        pop  = (m_cnt[k] > 0) && out_ready;
        push = enable && (c >= 0) && has_space(k);
        if (pop) begin
            m_head[k] = (m_head[k] + 1) % D;
            m_cnt[k]--;
        end
        if (push) begin
            r.ch = c; r.pc = ch_pc[c*32 +: 32]; r.instr = ch_instr[c*32 +: 32];
            r.wdata = ch_wdata[c*32 +: 32]; r.ts = m_ts[k];
            m_mem[k][(m_head[k] + m_cnt[k]) % D] = r;
            m_cnt[k]++;
            m_ptr[k] = (c + 1) % N;
        end
        if (k == 1 && enable) begin
            nv    = $countones(ch_valid);
            drops = nv - int'(push);
            if (drops > 0) begin
                m_ov[k] = 1'b1;
                m_dc[k] = (m_dc[k] + drops > 65535) ? 65535 : m_dc[k] + drops;
            end
        end
        if (enable) m_ts[k] = m_ts[k] + 32'd1;
    endtask

    task automatic check_all();
        mrec_t h;
        int    c;
        logic [N-1:0] er;
        for (int k = 0; k < 2; k++) begin
            chk("out_valid", k, 32'(ovld[k]), 32'(m_cnt[k] != 0));
            if (m_cnt[k] != 0) begin
                h = m_mem[k][m_head[k]];
                chk("out_channel", k, 32'(och[k]), h.ch);
                chk("out_pc", k, opc[k], h.pc);
                chk("out_instr", k, oins[k], h.instr);
                chk("out_wdata", k, owd[k], h.wdata);
                chk("out_timestamp", k, ots[k], h.ts);
            end
            chk("level", k, 32'(lvl[k]), m_cnt[k]);
            chk("drop_count", k, 32'(dcnt[k]), m_dc[k]);
            chk("overflow", k, 32'(ovf[k]), 32'(m_ov[k]));
            er = '1;
            if (k == 0 && enable) begin
                er = '0;
                c  = cand_of(0);
                if (c >= 0 && has_space(0)) er[c] = 1'b1;
            end
            chk("ch_ready", k, 32'(rdy[k]), 32'(er));
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cyc();
        #1 check_all();
        @(posedge clk);
        model_update(0);
        model_update(1);
        @(negedge clk);
    endtask

    task automatic set_ch(int c, logic [31:0] pc);
        ch_pc[c*32 +: 32]    = pc;
        ch_instr[c*32 +: 32] = pc ^ 32'h0013_0000;
        ch_wdata[c*32 +: 32] = ~pc;
    endtask

    task automatic do_clear();
        clear = 1'b1; ch_valid = '0; cyc(); clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0; out_ready = 1'b0;
        ch_valid = '0; ch_pc = '0; ch_instr = '0; ch_wdata = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("lit_reset_valid", k, 32'(ovld[k]), 0);
            chk("lit_reset_level", k, 32'(lvl[k]), 0);
            chk("lit_reset_drops", k, 32'(dcnt[k]), 0);
            chk("lit_reset_ovf", k, 32'(ovf[k]), 0);
        end

        // Single channel, three consecutive records, sink always ready.
        enable = 1'b1; out_ready = 1'b1; ch_valid = 3'b001;
        for (int i = 0; i < 3; i++) begin
            set_ch(0, 32'h80 + 32'(4 * i));
            cyc();
            chk("lit_seq_pc", 0, opc[0], 32'h80 + 32'(4 * i));
            chk("lit_seq_ts", 0, ots[0], 32'(i));
            chk("lit_seq_valid", 0, 32'(ovld[0]), 1);
        end
        ch_valid = '0; cyc();
        chk("lit_seq_drained", 0, 32'(ovld[0]), 0);

        // Two contending channels alternate grants.
        do_clear();
        ch_valid = 3'b011; set_ch(0, 32'h1000); set_ch(1, 32'h2000);
        for (int i = 0; i < 4; i++) begin
            #1 chk("lit_rr_ready", 0, 32'(rdy[0]), (i % 2 == 0) ? 32'h1 : 32'h2);
            cyc();
            chk("lit_rr_channel", 0, 32'(och[0]), 32'(i % 2));
        end

        // Fill with the sink stalled: drop instance loses two of six.
        do_clear();
        out_ready = 1'b0; ch_valid = 3'b001;
        for (int i = 0; i < 6; i++) begin
            set_ch(0, 32'h100 + 32'(4 * i));
            cyc();
        end
        chk("lit_fill_level", 1, 32'(lvl[1]), 4);
        chk("lit_fill_drops", 1, 32'(dcnt[1]), 2);
        chk("lit_fill_ovf", 1, 32'(ovf[1]), 1);
        chk("lit_fill_head", 1, opc[1], 32'h100);
        chk("lit_fill_level_stall", 0, 32'(lvl[0]), 4);
        chk("lit_fill_drops_stall", 0, 32'(dcnt[0]), 0);

        // Full FIFO, push and pop together.
        out_ready = 1'b1; set_ch(0, 32'h200); cyc();
        chk("lit_fullpp_level", 1, 32'(lvl[1]), 4);
        chk("lit_fullpp_drops", 1, 32'(dcnt[1]), 2);
        chk("lit_fullpp_head", 1, opc[1], 32'h104);

        // Three channels at once, then run the drop counter into saturation.
        do_clear();
        out_ready = 1'b0; ch_valid = 3'b111;
        set_ch(0, 32'hA0); set_ch(1, 32'hB0); set_ch(2, 32'hC0);
        cyc();
        chk("lit_multi_level", 1, 32'(lvl[1]), 1);
        chk("lit_multi_drops", 1, 32'(dcnt[1]), 2);
        for (int i = 0; i < 22000; i++) cyc();
        chk("lit_sat_drops", 1, 32'(dcnt[1]), 32'hFFFF);
        cyc();
        chk("lit_sat_hold", 1, 32'(dcnt[1]), 32'hFFFF);

        // Clear with three records pending; timestamp restarts.
        do_clear();
        ch_valid = 3'b001;
        for (int i = 0; i < 3; i++) begin set_ch(0, 32'h300 + 32'(i)); cyc(); end
        chk("lit_pre_clear_level", 1, 32'(lvl[1]), 3);
        do_clear();
        for (int k = 0; k < 2; k++) begin
            chk("lit_clear_level", k, 32'(lvl[k]), 0);
            chk("lit_clear_ovf", k, 32'(ovf[k]), 0);
        end
        ch_valid = 3'b001; set_ch(0, 32'h400); cyc();
        chk("lit_clear_ts", 1, ots[1], 0);

        // Asynchronous reset mid-stream.
        ch_valid = 3'b111;
        for (int i = 0; i < 6; i++) cyc();
        rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            chk("lit_arst_valid", k, 32'(ovld[k]), 0);
            chk("lit_arst_level", k, 32'(lvl[k]), 0);
            chk("lit_arst_drops", k, 32'(dcnt[k]), 0);
            chk("lit_arst_ovf", k, 32'(ovf[k]), 0);
        end
        #1 rst = 1'b0;
        ch_valid = 3'b010; set_ch(1, 32'h500); cyc();
        chk("lit_arst_ts", 0, ots[0], 0);
        chk("lit_arst_chan", 0, 32'(och[0]), 1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            ch_valid  = N'($urandom);
            enable    = ($urandom_range(0, 7) != 0);
            clear     = ($urandom_range(0, 63) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            for (int c = 0; c < N; c++) set_ch(c, $urandom);
            cyc();
        end
        clear = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
